// File: rtl/timer_bank.sv
// Multi-channel interval timer: NUM_CH channels share one prescaler tick.
// Optional interrupt status/mask/irq logic is enabled with `define TIMER_BANK_IRQ_EN.
module timer_bank #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int PRE_W     = 8,
  parameter int RST_LIMIT = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PRE_W-1:0]        prescale,
  input  logic [NUM_CH-1:0]       ch_ena,
  input  logic [NUM_CH-1:0]       ch_clr,
  input  logic [NUM_CH-1:0]       ch_mode,
  input  logic [NUM_CH-1:0]       ch_load_we,
  input  logic [NUM_CH*CNT_W-1:0] ch_load_val,
  output logic [NUM_CH-1:0]       ch_expire,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH*CNT_W-1:0] ch_count
`ifdef TIMER_BANK_IRQ_EN
  ,
  input  logic [NUM_CH-1:0]       irq_mask,
  input  logic [NUM_CH-1:0]       irq_ack,
  output logic                    irq
`endif
);

  localparam logic [CNT_W-1:0] LIMIT_RST = CNT_W'(RST_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PRE_W-1:0] PRE_ONE   = PRE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [PRE_W-1:0] pre_cnt_reg;
  logic [PRE_W-1:0] pre_cnt_next;
  logic             tick;

  // >= rather than == so lowering prescale at runtime never skips the wrap
  always_comb begin
    tick         = (pre_cnt_reg >= prescale);
    pre_cnt_next = tick ? '0 : pre_cnt_reg + PRE_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= pre_cnt_next;
    end
  end

`ifdef TIMER_BANK_IRQ_EN
  logic [NUM_CH-1:0] expire_next_vec;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;
      logic [CNT_W-1:0] limit_reg;
      logic [CNT_W-1:0] limit_next;
      logic             expire_reg;
      logic             expire_next;
      logic             busy;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_reg  <= ST_IDLE;
          count_reg  <= '0;
          limit_reg  <= LIMIT_RST;
          expire_reg <= 1'b0;
        end else begin
          state_reg  <= state_next;
          count_reg  <= count_next;
          limit_reg  <= limit_next;
          expire_reg <= expire_next;
        end
      end

      // The terminal compare uses limit_reg, so a same-cycle load takes effect afterwards
      always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        expire_next = 1'b0;
        limit_next  = ch_load_we[gi] ? ch_load_val[gi*CNT_W +: CNT_W] : limit_reg;
        if (ch_clr[gi] || !ch_ena[gi]) begin
          state_next = ST_IDLE;
          count_next = '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              state_next = ST_RUN;
            end
            ST_RUN: begin
              if (tick) begin
                if (count_reg >= limit_reg) begin
                  expire_next = 1'b1;
                  count_next  = '0;
                  if (!ch_mode[gi]) begin
                    state_next = ST_DONE;
                  end
                end else begin
                  count_next = count_reg + CNT_ONE;
                end
              end
            end
            ST_DONE: begin
              count_next = '0;
            end
            default: begin
              state_next = ST_IDLE;
              count_next = '0;
            end
          endcase
        end
      end

      always_comb begin
        busy = (state_reg == ST_RUN);
      end

      assign ch_expire[gi]                 = expire_reg;
      assign ch_busy[gi]                   = busy;
      assign ch_count[gi*CNT_W +: CNT_W]   = count_reg;
`ifdef TIMER_BANK_IRQ_EN
      assign expire_next_vec[gi]           = expire_next;
`endif
    end
  endgenerate

`ifdef TIMER_BANK_IRQ_EN
  logic [NUM_CH-1:0] irq_status_reg;
  logic [NUM_CH-1:0] irq_status_next;
  logic              irq_reg;
  logic              irq_next;

  // Status sets on the same edge as ch_expire; a coinciding ack loses to the set
  always_comb begin
    irq_status_next = (irq_status_reg & ~irq_ack) | expire_next_vec;
    irq_next        = |(irq_status_reg & irq_mask);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_status_reg <= '0;
      irq_reg        <= 1'b0;
    end else begin
      irq_status_reg <= irq_status_next;
      irq_reg        <= irq_next;
    end
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Scoreboard bench for timer_bank: a behavioural model queues the expected
// outputs of every clock, which are compared at the following falling edge.
module tb_timer_bank;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;
  localparam int PRE_W  = 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [PRE_W-1:0]        prescale = '0;
  logic [NUM_CH-1:0]       ch_ena = '0;
  logic [NUM_CH-1:0]       ch_clr = '0;
  logic [NUM_CH-1:0]       ch_mode = '0;
  logic [NUM_CH-1:0]       ch_load_we = '0;
  logic [NUM_CH*CNT_W-1:0] ch_load_val = '0;
  logic [NUM_CH-1:0]       ch_expire;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH*CNT_W-1:0] ch_count;
  logic                    irq_obs;
`ifdef TIMER_BANK_IRQ_EN
  logic [NUM_CH-1:0]       irq_mask = '0;
  logic [NUM_CH-1:0]       irq_ack = '0;
  logic                    irq;
  assign irq_obs = irq;
`else
  assign irq_obs = 1'b0;
`endif

  timer_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W), .RST_LIMIT(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prescale(prescale),
    .ch_ena(ch_ena),
    .ch_clr(ch_clr),
    .ch_mode(ch_mode),
    .ch_load_we(ch_load_we),
    .ch_load_val(ch_load_val),
    .ch_expire(ch_expire),
    .ch_busy(ch_busy),
    .ch_count(ch_count)
`ifdef TIMER_BANK_IRQ_EN
    ,
    .irq_mask(irq_mask),
    .irq_ack(irq_ack),
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       expire;
    logic [NUM_CH-1:0]       busy;
    logic                    irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Behavioural model: 0 idle, 1 running, 2 one-shot finished
  logic [CNT_W-1:0]  m_count [NUM_CH];
  logic [CNT_W-1:0]  m_limit [NUM_CH];
  int                m_st    [NUM_CH];
  logic [NUM_CH-1:0] m_exp;
  logic [PRE_W-1:0]  m_pre;
  logic [NUM_CH-1:0] m_status;
  logic              m_irq;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_count[i] = '0;
      m_limit[i] = 32'd256;
      m_st[i]    = 0;
    end
    m_exp    = '0;
    m_pre    = '0;
    m_status = '0;
    m_irq    = 1'b0;
  endtask

  task automatic model_clock();
    logic             tk;
    logic [CNT_W-1:0] lim_old;
    tk = (m_pre >= prescale);
    for (int i = 0; i < NUM_CH; i++) begin
      lim_old  = m_limit[i];
      m_exp[i] = 1'b0;
      if (ch_load_we[i]) m_limit[i] = ch_load_val[i*CNT_W +: CNT_W];
      if (ch_clr[i] || !ch_ena[i]) begin
        m_count[i] = '0;
        m_st[i]    = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1;
      end else if (m_st[i] == 1 && tk) begin
        if (m_count[i] >= lim_old) begin
          m_exp[i]   = 1'b1;
          m_count[i] = '0;
          if (!ch_mode[i]) m_st[i] = 2;
        end else begin
          m_count[i] = m_count[i] + 1;
        end
      end
    end
`ifdef TIMER_BANK_IRQ_EN
    m_irq    = |(m_status & irq_mask);
    m_status = (m_status & ~irq_ack) | m_exp;
`endif
    m_pre = tk ? '0 : m_pre + 1'b1;
  endtask

  // One clock: model the edge, queue the expectation, compare after the edge
  task automatic step();
    exp_t e;
    model_clock();
    for (int i = 0; i < NUM_CH; i++) begin
      e.count[i*CNT_W +: CNT_W] = m_count[i];
      e.busy[i]                 = (m_st[i] == 1);
    end
    e.expire = m_exp;
    e.irq    = m_irq;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = sb_q.pop_front();
    chk("count", ch_count, e.count);
    chk("expire", ch_expire, e.expire);
    chk("busy", ch_busy, e.busy);
`ifdef TIMER_BANK_IRQ_EN
    chk("irq", irq_obs, e.irq);
`endif
    $display("[TB] cyc=%0d pre=%0d ena=%b exp=%b busy=%b irq=%b cnt=%0d/%0d/%0d/%0d",
             cyc, prescale, ch_ena, ch_expire, ch_busy, irq_obs,
             ch_count[31:0], ch_count[63:32], ch_count[95:64], ch_count[127:96]);
    ch_clr     = '0;
    ch_load_we = '0;
`ifdef TIMER_BANK_IRQ_EN
    irq_ack    = '0;
`endif
  endtask

  task automatic load(input int ch, input logic [CNT_W-1:0] v);
    ch_load_we[ch]               = 1'b1;
    ch_load_val[ch*CNT_W +: CNT_W] = v;
  endtask

  initial begin
    int pulses;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", ch_count, '0);
    chk("rst_expire", ch_expire, '0);
    chk("rst_busy", ch_busy, '0);
    chk("rst_irq", irq_obs, 1'b0);
    rst = 1'b0;

    // ch0 periodic, limit 3, prescale 0: pulses at edges 4, 8, 12
    load(0, 32'd3);
    ch_mode[0] = 1'b1;
    step();
    for (int k = 0; k <= 12; k++) begin
      ch_ena[0] = 1'b1;
      step();
      if (k >= 1) begin
        chk("p_count0", ch_count[31:0], 128'(k % 4));
        chk("p_exp0", ch_expire[0], (k % 4 == 0) ? 1 : 0);
      end
    end
    ch_ena[0] = 1'b0;
    step();

    // ch1 one-shot, limit 1, prescale 2: single pulse at edge 5
    load(1, 32'd1);
    ch_mode[1] = 1'b0;
    step();
    prescale  = 8'd2;
    ch_ena[1] = 1'b1;
    pulses    = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ch_expire[1]) pulses++;
      if (k == 4) chk("os_busy_before", ch_busy[1], 1'b1);
      if (k == 5) begin
        chk("os_exp", ch_expire[1], 1'b1);
        chk("os_busy_drop", ch_busy[1], 1'b0);
      end
    end
    chk("os_pulses", pulses, 1);
    ch_ena[1] = 1'b0;
    step();
    ch_ena[1] = 1'b1;
    pulses    = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (ch_expire[1]) pulses++;
    end
    chk("os_rearm_pulses", pulses, 1);
    ch_ena[1] = 1'b0;

    // ch2 counting at 10 with limit 20, reload with 5
    prescale = 8'd0;
    load(2, 32'd20);
    ch_mode[2] = 1'b1;
    step();
    ch_ena[2] = 1'b1;
    for (int k = 0; k <= 10; k++) step();
    chk("ld_count10", ch_count[95:64], 128'd10);
    load(2, 32'd5);
    step();
    chk("ld_count11", ch_count[95:64], 128'd11);
    chk("ld_noexp", ch_expire[2], 1'b0);
    step();
    chk("ld_exp", ch_expire[2], 1'b1);
    chk("ld_count0", ch_count[95:64], 128'd0);
    ch_ena[2] = 1'b0;
    step();

    // ch3 clear on the terminal tick suppresses the expiry
    load(3, 32'd2);
    ch_mode[3] = 1'b1;
    step();
    ch_ena[3] = 1'b1;
    for (int k = 0; k <= 2; k++) step();
    chk("clr_pre_count", ch_count[127:96], 128'd2);
    ch_clr[3] = 1'b1;
    step();
    chk("clr_exp", ch_expire[3], 1'b0);
    chk("clr_count", ch_count[127:96], 128'd0);
    chk("clr_busy", ch_busy[3], 1'b0);
    ch_ena[3] = 1'b0;
    step();
    chk("clr_busy_idle", ch_busy[3], 1'b0);

`ifdef TIMER_BANK_IRQ_EN
    // ch0 limit 3 again: irq one clock after expiry; ack coinciding with expiry loses
    irq_mask = 4'b0001;
    irq_ack  = 4'hF;
    step();
    for (int k = 0; k <= 12; k++) begin
      ch_ena[0] = (k < 10);
      if (k == 8 || k == 11) irq_ack[0] = 1'b1;
      step();
      if (k == 4) chk("irq_before", irq, 1'b0);
      if (k == 5) chk("irq_rise", irq, 1'b1);
      if (k == 9) chk("irq_ack_vs_set", irq, 1'b1);
      if (k == 12) chk("irq_acked", irq, 1'b0);
    end
    irq_mask = '0;
`endif

    // limit 0 expires every tick
    load(0, 32'd0);
    ch_mode[0] = 1'b1;
    step();
    ch_ena[0] = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("lim0_exp", ch_expire[0], 1'b1);
    end

    // asynchronous reset mid-stream
    rst = 1'b1;
    #1;
    chk("arst_count", ch_count, '0);
    chk("arst_expire", ch_expire, '0);
    chk("arst_busy", ch_busy, '0);
    chk("arst_irq", irq_obs, 1'b0);
    model_reset();
    ch_ena  = '0;
    ch_mode = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset limit of 256 on ch0
    ch_mode[0] = 1'b1;
    ch_ena[0]  = 1'b1;
    step();
    for (int k = 1; k <= 258; k++) begin
      step();
      if (k == 256) chk("rstlim_count", ch_count[31:0], 128'd256);
      if (k == 257) chk("rstlim_exp", ch_expire[0], 1'b1);
    end

    // randomised traffic against the model
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 15) == 0) prescale = 8'($urandom_range(0, 3));
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 7) == 0) ch_ena[i] = ~ch_ena[i];
        if ($urandom_range(0, 15) == 0) ch_clr[i] = 1'b1;
        if ($urandom_range(0, 7) == 0) load(i, 32'($urandom_range(0, 6)));
        if ($urandom_range(0, 15) == 0) ch_mode[i] = ~ch_mode[i];
      end
`ifdef TIMER_BANK_IRQ_EN
      irq_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) irq_ack = 4'($urandom_range(0, 15));
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
